reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
Parametrised multi-port integer register file for the next CPU core revision. It has NUM_RD combinational read ports and NUM_WR write ports with deterministic priority. Register x0 is hardwired to zero, and an optional write-to-read bypass is provided. A per-register busy scoreboard lets the decode stage detect RAW hazards against in-flight producers. It sits between decode (reads, issue) and writeback (writes), and keeps the a0 observation output used by testbenches.

Parameters:
ADDRESS_WIDTH, 5, register index width; NREG = 2**ADDRESS_WIDTH registers
DATA_WIDTH, 32, register width in bits
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 1, number of write ports (1..2)
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return pre-write contents

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
rd_addr  input  NUM_RD*ADDRESS_WIDTH  read addresses, port i at slice [i*AW +: AW]
rd_data  output  NUM_RD*DATA_WIDTH  read data, port i at slice [i*DW +: DW]
rd_busy  output  NUM_RD  scoreboard busy flag for each read address
wr_en  input  NUM_WR  write enables
wr_addr  input  NUM_WR*ADDRESS_WIDTH  write addresses
wr_data  input  NUM_WR*DATA_WIDTH  write data
issue_en  input  1  mark issue_addr busy (producer issued)
issue_addr  input  ADDRESS_WIDTH  destination of the issued instruction
busy_count  output  ADDRESS_WIDTH+1  registered count of busy registers
a0  output  DATA_WIDTH  contents of register 10 (x10)

Behaviour:
- Reset: at a rising edge with rst=1, all NREG registers clear to 0, all busy bits clear to 0, and busy_count goes to 0. Writes and issues in that cycle are dropped. After reset, all rd_data = 0, rd_busy = 0, a0 = 0. Reset mid-operation discards all pending busy state.
- Write: at a rising edge with wr_en[j]=1 and wr_addr[j]!=0, register wr_addr[j] takes wr_data[j]. Write latency is 1 cycle.
- Write priority: if both write ports target the same address in the same cycle, the higher port index wins.
- x0: writes to x0 are ignored, reads of x0 return 0 (also under bypass), issue to x0 is ignored, and rd_busy for x0 is always 0.
- Read: combinational, zero-latency.
  - BYPASS=1: if any enabled write with a nonzero address matches rd_addr[i], rd_data[i] = wr_data of the highest-index matching port.
  - BYPASS=0: rd_data[i] returns the stored value; the new value is visible the cycle after the edge.
- Scoreboard, per register r (r != 0), with next state at the rising edge:
  - Set when issue_en=1 and issue_addr=r.
  - Cleared when any wr_en[j]=1 and wr_addr[j]=r.
  - Issue and writeback to the same r in the same cycle: the busy bit ends set (new producer wins).
  - Issue to an already-busy register: it stays busy; there is no counting of multiple producers.
- rd_busy[i] = busy[rd_addr[i]]. With BYPASS=1 it is additionally masked to 0 when a same-cycle enabled write hits rd_addr[i], since the value is being forwarded.
- busy_count is registered: it equals the number of busy bits after each edge, ranges 0..NREG-1, and cannot overflow.
- a0 reflects the stored x10 value and is never bypassed.
- All out-of-range parameter combinations are rejected at elaboration by an assertion.

Test Plan:
- Reset and x0: write 0xDEADBEEF to x0, then write 0x1234 to x5, then pulse rst → reads of x0 = 0 throughout; reads of x5 = 0 after rst; busy_count = 0; a0 = 0.
- Write and bypass: BYPASS=1, write x10 = 0xA5A5A5A5 while rd_addr[0]=10 → rd_data[0] = 0xA5A5A5A5 in the same cycle and a0 = 0xA5A5A5A5 next cycle. With BYPASS=0, rd_data[0] shows the old value (0) in the same cycle.
- Dual-write conflict: NUM_WR=2, port0 writes x7=0x11 and port1 writes x7=0x22 in one cycle → x7 reads 0x22. Separate addresses x3=1 and x4=2 in one cycle → both stored.
- Scoreboard set/clear: issue x8 → rd_busy = 1 and busy_count = 1 next cycle. Write x8 → busy cleared, busy_count = 0. Issue and write x8 in the same cycle → still busy, busy_count = 1.
- Busy masking and count: issue x1..x31 over consecutive cycles → busy_count = 31. Issue to x0 → no change. Reset mid-sequence → busy_count = 0 and all rd_busy = 0 on the next cycle.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port integer register file with hardwired x0,
// optional write-to-read forwarding, and a per-register busy scoreboard
// so decode can spot RAW hazards against in-flight producers.
module reg_file_mp #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_RD        = 2,
    parameter int NUM_WR        = 1,
    parameter int BYPASS        = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_RD*ADDRESS_WIDTH-1:0]   rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]      rd_data,
    output logic [NUM_RD-1:0]                 rd_busy,
    input  logic [NUM_WR-1:0]                 wr_en,
    input  logic [NUM_WR*ADDRESS_WIDTH-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0]      wr_data,
    input  logic                              issue_en,
    input  logic [ADDRESS_WIDTH-1:0]          issue_addr,
    output logic [ADDRESS_WIDTH:0]            busy_count,
    output logic [DATA_WIDTH-1:0]             a0
);

    localparam int AW   = ADDRESS_WIDTH;
    localparam int DW   = DATA_WIDTH;
    localparam int NREG = 1 << ADDRESS_WIDTH;
    // x10 is the ABI a0 register exposed for observation.
    localparam logic [ADDRESS_WIDTH-1:0] A0_IDX = ADDRESS_WIDTH'(10);

    // Reject unsupported parameter combinations at elaboration.
    generate
        if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
            $error("reg_file_mp: NUM_RD must be 1..4");
        end
        if (NUM_WR < 1 || NUM_WR > 2) begin : g_bad_num_wr
            $error("reg_file_mp: NUM_WR must be 1..2");
        end
        if (BYPASS != 0 && BYPASS != 1) begin : g_bad_bypass
            $error("reg_file_mp: BYPASS must be 0 or 1");
        end
        if (ADDRESS_WIDTH < 4 || ADDRESS_WIDTH > 8) begin : g_bad_aw
            $error("reg_file_mp: ADDRESS_WIDTH must be 4..8 (x10 must exist)");
        end
        if (DATA_WIDTH < 1) begin : g_bad_dw
            $error("reg_file_mp: DATA_WIDTH must be at least 1");
        end
    endgenerate

    // Unpacked views of the write ports; a write to x0 is never "valid".
    logic [AW-1:0] w_wr_addr  [NUM_WR];
    logic [DW-1:0] w_wr_data  [NUM_WR];
    logic          w_wr_valid [NUM_WR];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WR; gi++) begin : g_wr_split
            assign w_wr_addr[gi]  = wr_addr[gi*AW +: AW];
            assign w_wr_data[gi]  = wr_data[gi*DW +: DW];
            assign w_wr_valid[gi] = wr_en[gi] && (wr_addr[gi*AW +: AW] != '0);
        end
    endgenerate

    logic [DW-1:0]   r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic [AW:0]     r_busy_count;
    logic [NREG-1:0] w_busy_next;
    logic [AW:0]     w_count_next;

    // Register storage: ports applied in ascending order so the highest
    // index wins an address conflict; reset drops any same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (w_wr_valid[j]) begin
                    r_regs[w_wr_addr[j]] <= w_wr_data[j];
                end
            end
        end
    end

    // Scoreboard next state: writebacks clear, then issue sets, so a new
    // producer issued alongside the old one's writeback keeps the bit set.
    always_comb begin
        w_busy_next = r_busy;
        for (int j = 0; j < NUM_WR; j++) begin
            if (w_wr_valid[j]) begin
                w_busy_next[w_wr_addr[j]] = 1'b0;
            end
        end
        if (issue_en) begin
            w_busy_next[issue_addr] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    // Population count of the next busy vector; at most NREG-1 since x0
    // can never be busy, so AW+1 bits cannot overflow.
    always_comb begin
        w_count_next = '0;
        for (int r = 0; r < NREG; r++) begin
            w_count_next = w_count_next + {{AW{1'b0}}, w_busy_next[r]};
        end
    end

    // Scoreboard and count registers; reset discards all pending producers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            r_busy       <= w_busy_next;
            r_busy_count <= w_count_next;
        end
    end

    // Read ports: zero-latency lookup with optional forwarding.
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [AW-1:0] w_addr;
            logic [DW-1:0] w_data;
            logic          w_busy;

            assign w_addr = rd_addr[gi*AW +: AW];

            // Stored value first, overridden by matching writes in ascending
            // port order; a forwarded value is no longer a hazard.
            always_comb begin
                w_data = r_regs[w_addr];
                w_busy = r_busy[w_addr];
                if (BYPASS == 1) begin
                    for (int j = 0; j < NUM_WR; j++) begin
                        if (w_wr_valid[j] && (w_wr_addr[j] == w_addr)) begin
                            w_data = w_wr_data[j];
                            w_busy = 1'b0;
                        end
                    end
                end
                if (w_addr == '0) begin
                    w_data = '0;
                    w_busy = 1'b0;
                end
            end

            assign rd_data[gi*DW +: DW] = w_data;
            assign rd_busy[gi]          = w_busy;
        end
    endgenerate

    assign busy_count = r_busy_count;
    assign a0         = r_regs[A0_IDX];

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: drives a forwarding and a non-forwarding instance of
// reg_file_mp (both dual-write, dual-read) with directed and random traffic
// and compares them against a behavioural register/scoreboard model.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_a [2];
    logic        we   [2];
    logic [4:0]  wa   [2];
    logic [31:0] wd   [2];
    logic        issue_en;
    logic [4:0]  issue_addr;

    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;

    logic [63:0] b_rd_data, n_rd_data;
    logic [1:0]  b_rd_busy, n_rd_busy;
    logic [5:0]  b_cnt, n_cnt;
    logic [31:0] b_a0, n_a0;

    // Index 0 = forwarding instance, 1 = non-forwarding instance.
    logic [31:0] o_data [2][2];
    logic        o_busy [2][2];
    logic [5:0]  o_cnt  [2];
    logic [31:0] o_a0   [2];

    // Behavioural model.
    logic [31:0] m_regs [32];
    logic [31:0] m_busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign rd_addr = {rd_a[1], rd_a[0]};
    assign wr_en   = {we[1], we[0]};
    assign wr_addr = {wa[1], wa[0]};
    assign wr_data = {wd[1], wd[0]};

    assign o_data[0][0] = b_rd_data[31:0];
    assign o_data[0][1] = b_rd_data[63:32];
    assign o_data[1][0] = n_rd_data[31:0];
    assign o_data[1][1] = n_rd_data[63:32];
    assign o_busy[0][0] = b_rd_busy[0];
    assign o_busy[0][1] = b_rd_busy[1];
    assign o_busy[1][0] = n_rd_busy[0];
    assign o_busy[1][1] = n_rd_busy[1];
    assign o_cnt[0]     = b_cnt;
    assign o_cnt[1]     = n_cnt;
    assign o_a0[0]      = b_a0;
    assign o_a0[1]      = n_a0;

    reg_file_mp #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
        .issue_addr(issue_addr), .busy_count(b_cnt), .a0(b_a0)
    );

    reg_file_mp #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(n_rd_data), .rd_busy(n_rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
        .issue_addr(issue_addr), .busy_count(n_cnt), .a0(n_a0)
    );

    // Expected read value: x0 is zero; with forwarding the highest-numbered
    // enabled write to the address supplies the value; otherwise storage.
    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp) begin
            if (we[1] && wa[1] == a) return wd[1];
            if (we[0] && wa[0] == a) return wd[0];
        end
        return m_regs[a];
    endfunction

    // Expected busy flag: x0 never busy; a forwarded value is not a hazard.
    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 1'b0;
        if (byp && ((we[0] && wa[0] == a) || (we[1] && wa[1] == a))) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic set_idle();
        rst      = 1'b0;
        we[0]    = 1'b0; we[1] = 1'b0;
        wa[0]    = 5'd0; wa[1] = 5'd0;
        wd[0]    = 32'd0; wd[1] = 32'd0;
        issue_en = 1'b0;
        issue_addr = 5'd0;
    endtask

    // One rising edge: the model applies the same rules as the hardware.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
            m_busy = 32'd0;
        end else begin
            if (we[0] && wa[0] != 5'd0) m_regs[wa[0]] = wd[0];
            if (we[1] && wa[1] != 5'd0) m_regs[wa[1]] = wd[1];
            if (we[0] && wa[0] != 5'd0) m_busy[wa[0]] = 1'b0;
            if (we[1] && wa[1] != 5'd0) m_busy[wa[1]] = 1'b0;
            if (issue_en && issue_addr != 5'd0) m_busy[issue_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hFFFF_FFFF;
        issue_en = 1'b1; issue_addr = 5'd5;
        tick();
        set_idle();
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (o_cnt[d] !== 6'd0) $display("FAIL reset_count dut=%0d got=%0d exp=0", d, o_cnt[d]);
            else n_pass++;
            n_total++;
            if (o_a0[d] !== 32'd0) $display("FAIL reset_a0 dut=%0d got=%h exp=0", d, o_a0[d]);
            else n_pass++;
        end
        for (int a = 0; a < 32; a++) begin
            rd_a[0] = 5'(a);
            rd_a[1] = 5'(31 - a);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    n_total++;
                    if ({o_busy[d][p], o_data[d][p]} !== 33'd0)
                        $display("FAIL reset_read dut=%0d port=%0d addr=%0d got=%h/%b exp=0/0",
                                 d, p, rd_a[p], o_data[d][p], o_busy[d][p]);
                    else n_pass++;
                end
            end
        end
        tick();
    endtask

    task automatic test_x0();
        set_idle();
        rd_a[0] = 5'd0; rd_a[1] = 5'd5;
        we[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'hDEAD_BEEF;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (o_data[d][0] !== 32'd0) $display("FAIL x0_write_bypass dut=%0d got=%h exp=0", d, o_data[d][0]);
            else n_pass++;
        end
        tick();
        set_idle();
        #1;
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (o_data[d][0] !== 32'd0) $display("FAIL x0_read dut=%0d got=%h exp=0", d, o_data[d][0]);
            else n_pass++;
        end
        we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'h0000_1234;
        tick();
        set_idle();
        #1;
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (o_data[d][1] !== 32'h1234) $display("FAIL x5_stored dut=%0d got=%h exp=1234", d, o_data[d][1]);
            else n_pass++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (o_data[d][1] !== 32'd0) $display("FAIL x5_after_rst dut=%0d got=%h exp=0", d, o_data[d][1]);
            else n_pass++;
            n_total++;
            if (o_data[d][0] !== 32'd0) $display("FAIL x0_after_rst dut=%0d got=%h exp=0", d, o_data[d][0]);
            else n_pass++;
            n_total++;
            if (o_cnt[d] !== 6'd0 || o_a0[d] !== 32'd0)
                $display("FAIL rst_cnt_a0 dut=%0d got=%0d/%h exp=0/0", d, o_cnt[d], o_a0[d]);
            else n_pass++;
        end
    endtask

    task automatic test_bypass();
        set_idle();
        rd_a[0] = 5'd10; rd_a[1] = 5'd0;
        we[0] = 1'b1; wa[0] = 5'd10; wd[0] = 32'hA5A5_A5A5;
        #1;
        n_total++;
        if (o_data[0][0] !== 32'hA5A5_A5A5) $display("FAIL bypass_same_cycle got=%h exp=a5a5a5a5", o_data[0][0]);
        else n_pass++;
        n_total++;
        if (o_data[1][0] !== 32'd0) $display("FAIL nobypass_old_value got=%h exp=0", o_data[1][0]);
        else n_pass++;
        n_total++;
        if (o_a0[0] !== 32'd0) $display("FAIL a0_not_bypassed got=%h exp=0", o_a0[0]);
        else n_pass++;
        tick();
        set_idle();
        #1;
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (o_a0[d] !== 32'hA5A5_A5A5) $display("FAIL a0_next_cycle dut=%0d got=%h exp=a5a5a5a5", d, o_a0[d]);
            else n_pass++;
            n_total++;
            if (o_data[d][0] !== 32'hA5A5_A5A5) $display("FAIL x10_stored dut=%0d got=%h exp=a5a5a5a5", d, o_data[d][0]);
            else n_pass++;
        end
    endtask

    task automatic test_dual_write();
        set_idle();
        rd_a[0] = 5'd0; rd_a[1] = 5'd7;
        we[0] = 1'b1; wa[0] = 5'd7; wd[0] = 32'h11;
        we[1] = 1'b1; wa[1] = 5'd7; wd[1] = 32'h22;
        #1;
        n_total++;
        if (o_data[0][1] !== 32'h22) $display("FAIL dual_bypass_priority got=%h exp=22", o_data[0][1]);
        else n_pass++;
        tick();
        set_idle();
        #1;
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (o_data[d][1] !== 32'h22) $display("FAIL dual_write_priority dut=%0d got=%h exp=22", d, o_data[d][1]);
            else n_pass++;
        end
        we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'd1;
        we[1] = 1'b1; wa[1] = 5'd4; wd[1] = 32'd2;
        tick();
        set_idle();
        rd_a[0] = 5'd3; rd_a[1] = 5'd4;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (o_data[d][0] !== 32'd1 || o_data[d][1] !== 32'd2)
                $display("FAIL dual_write_split dut=%0d got=%h,%h exp=1,2", d, o_data[d][0], o_data[d][1]);
            else n_pass++;
        end
    endtask

    task automatic test_scoreboard();
        set_idle();
        rd_a[0] = 5'd8; rd_a[1] = 5'd0;
        issue_en = 1'b1; issue_addr = 5'd8;
        tick();
        set_idle();
        #1;
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (o_busy[d][0] !== 1'b1 || o_cnt[d] !== 6'd1)
                $display("FAIL sb_issue dut=%0d got=%b/%0d exp=1/1", d, o_busy[d][0], o_cnt[d]);
            else n_pass++;
        end
        we[0] = 1'b1; wa[0] = 5'd8; wd[0] = 32'h88;
        #1;
        n_total++;
        if (o_busy[0][0] !== 1'b0) $display("FAIL sb_bypass_mask got=%b exp=0", o_busy[0][0]);
        else n_pass++;
        n_total++;
        if (o_busy[1][0] !== 1'b1) $display("FAIL sb_nobypass_busy got=%b exp=1", o_busy[1][0]);
        else n_pass++;
        tick();
        set_idle();
        #1;
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (o_busy[d][0] !== 1'b0 || o_cnt[d] !== 6'd0)
                $display("FAIL sb_clear dut=%0d got=%b/%0d exp=0/0", d, o_busy[d][0], o_cnt[d]);
            else n_pass++;
        end
        we[0] = 1'b1; wa[0] = 5'd8; wd[0] = 32'h99;
        issue_en = 1'b1; issue_addr = 5'd8;
        tick();
        set_idle();
        #1;
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (o_busy[d][0] !== 1'b1 || o_cnt[d] !== 6'd1)
                $display("FAIL sb_issue_wins dut=%0d got=%b/%0d exp=1/1", d, o_busy[d][0], o_cnt[d]);
            else n_pass++;
        end
    endtask

    task automatic test_busy_fill();
        set_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int r = 1; r < 32; r++) begin
            issue_en = 1'b1; issue_addr = 5'(r);
            tick();
            n_total++;
            if (o_cnt[0] !== 6'(r)) $display("FAIL fill_count r=%0d got=%0d exp=%0d", r, o_cnt[0], r);
            else n_pass++;
        end
        issue_addr = 5'd0;
        tick();
        set_idle();
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (o_cnt[d] !== 6'd31) $display("FAIL fill_x0_ignored dut=%0d got=%0d exp=31", d, o_cnt[d]);
            else n_pass++;
        end
        for (int a = 0; a < 32; a++) begin
            rd_a[0] = 5'(a); rd_a[1] = 5'(a);
            @(negedge clk);
            n_total++;
            if (o_busy[1][1] !== (a != 0)) $display("FAIL fill_busy addr=%0d got=%b exp=%b", a, o_busy[1][1], a != 0);
            else n_pass++;
        end
        issue_en = 1'b1; issue_addr = 5'd5;
        rst = 1'b1;
        tick();
        set_idle();
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (o_cnt[d] !== 6'd0) $display("FAIL mid_reset_count dut=%0d got=%0d exp=0", d, o_cnt[d]);
            else n_pass++;
        end
        for (int a = 0; a < 32; a++) begin
            rd_a[0] = 5'(a); rd_a[1] = 5'(31 - a);
            @(negedge clk);
            n_total++;
            if (o_busy[0][0] !== 1'b0 || o_busy[1][1] !== 1'b0)
                $display("FAIL mid_reset_busy addr=%0d got=%b,%b exp=0,0", a, o_busy[0][0], o_busy[1][1]);
            else n_pass++;
        end
        tick();
    endtask

    // Biased address: a quarter of picks land in x6..x9 to provoke conflicts.
    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(6, 9));
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst        = ($urandom_range(0, 63) == 0);
            we[0]      = 1'($urandom_range(0, 1));
            we[1]      = 1'($urandom_range(0, 1));
            wa[0]      = rand_addr();
            wa[1]      = rand_addr();
            wd[0]      = $urandom;
            wd[1]      = $urandom;
            issue_en   = 1'($urandom_range(0, 1));
            issue_addr = rand_addr();
            rd_a[0]    = rand_addr();
            rd_a[1]    = rand_addr();
            #1;
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    n_total++;
                    if (o_data[d][p] !== exp_rd(rd_a[p], d == 0) || o_busy[d][p] !== exp_busy(rd_a[p], d == 0))
                        $display("FAIL rand_read cyc=%0d dut=%0d port=%0d addr=%0d got=%h/%b exp=%h/%b",
                                 c, d, p, rd_a[p], o_data[d][p], o_busy[d][p],
                                 exp_rd(rd_a[p], d == 0), exp_busy(rd_a[p], d == 0));
                    else n_pass++;
                end
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                n_total++;
                if (o_cnt[d] !== 6'($countones(m_busy)) || o_a0[d] !== m_regs[10])
                    $display("FAIL rand_state cyc=%0d dut=%0d got=%0d/%h exp=%0d/%h",
                             c, d, o_cnt[d], o_a0[d], $countones(m_busy), m_regs[10]);
                else n_pass++;
            end
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        rd_a[0] = 5'd0; rd_a[1] = 5'd0;
        for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
        m_busy = 32'd0;
        test_reset();
        test_x0();
        test_bypass();
        test_dual_write();
        test_scoreboard();
        test_busy_fill();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
